// File: rtl/rll_key_loader.sv
`default_nettype none
// ============================================================================
//  Module      : rll_key_loader
//  Description : Fetches the RLL key for a locked netlist as CHUNK_W-bit beats
//                over a valid/ready stream, verifies an XOR checksum beat and
//                commits the key only as a complete, verified word. Retries a
//                failed load and latches a sticky fault after MAX_RETRY
//                failed attempts.
//  Revision    : 1.0 - initial release
// ============================================================================
module rll_key_loader #(
    parameter int KEY_W     = 16,
    parameter int CHUNK_W   = 4,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    output logic               kd_req_o,
    input  logic               kd_valid_i,
    input  logic [CHUNK_W-1:0] kd_data_i,
    output logic               kd_ready_o,
    output logic [KEY_W-1:0]   key_out_o,
    output logic               key_valid_o,
    output logic               busy_o,
    output logic               fault_o,
    output logic [3:0]         retry_cnt_o
);

    // Number of data beats per key; a checksum beat follows them.
    localparam int c_NBEAT  = KEY_W / CHUNK_W;
    // Beat index width; at least one bit so a single-beat key still elaborates.
    localparam int c_BEAT_W = (c_NBEAT > 1) ? $clog2(c_NBEAT) : 1;
    // Idle timer only ever reaches TIMEOUT-1 before the load is abandoned.
    localparam int c_TMR_W  = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_LOAD  = 3'd2,
        S_CHECK = 3'd3,
        S_FAIL  = 3'd4,
        S_ARMED = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    state_t               state_q,     state_d;
    logic [KEY_W-1:0]     shadow_q,    shadow_d;
    logic [c_BEAT_W-1:0]  beat_q,      beat_d;
    logic [CHUNK_W-1:0]   xor_q,       xor_d;
    logic [c_TMR_W-1:0]   timer_q,     timer_d;
    logic [KEY_W-1:0]     key_q,       key_d;
    logic                 key_valid_q, key_valid_d;
    logic [3:0]           retry_q,     retry_d;

    logic                 w_ready;
    logic                 w_xfer;
    logic                 w_timeout;
    logic                 w_last_beat;
    logic [3:0]           w_retry_inc;

    // The stream is only open while a key is actually being collected.
    assign w_ready     = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign w_xfer      = kd_valid_i && w_ready;
    assign w_timeout   = (timer_q == c_TMR_W'(TIMEOUT - 1));
    assign w_last_beat = (beat_q == c_BEAT_W'(c_NBEAT - 1));
    assign w_retry_inc = retry_q + 4'd1;

    // Next-state and datapath decisions; every register holds by default.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        beat_d      = beat_q;
        xor_d       = xor_q;
        timer_d     = timer_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        retry_d     = retry_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    retry_d = 4'd0;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                // Fresh attempt: nothing from a previous try may leak into it.
                shadow_d = '0;
                beat_d   = '0;
                xor_d    = '0;
                timer_d  = '0;
                state_d  = S_LOAD;
            end

            S_LOAD: begin
                if (w_xfer) begin
                    // MSB chunk arrives first; constant-base selects per beat.
                    for (int b = 0; b < c_NBEAT; b++) begin
                        if (beat_q == c_BEAT_W'(b)) begin
                            shadow_d[KEY_W-1-CHUNK_W*b -: CHUNK_W] = kd_data_i;
                        end
                    end
                    xor_d   = xor_q ^ kd_data_i;
                    beat_d  = beat_q + 1'b1;
                    timer_d = '0;
                    if (w_last_beat) begin
                        state_d = S_CHECK;
                    end
                end else if (w_timeout) begin
                    state_d = S_FAIL;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_CHECK: begin
                if (w_xfer) begin
                    timer_d = '0;
                    if (kd_data_i == xor_q) begin
                        // Shadow and valid flag move together so the netlist
                        // never sees a key that is not verified.
                        key_d       = shadow_q;
                        key_valid_d = 1'b1;
                        state_d     = S_ARMED;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else if (w_timeout) begin
                    state_d = S_FAIL;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_FAIL: begin
                retry_d = w_retry_inc;
                if (w_retry_inc == 4'(MAX_RETRY)) begin
                    key_d       = '0;
                    key_valid_d = 1'b0;
                    state_d     = S_FAULT;
                end else begin
                    state_d = S_REQ;
                end
            end

            S_ARMED: begin
                if (start_i) begin
                    // Old key stays on key_out but is no longer vouched for.
                    key_valid_d = 1'b0;
                    retry_d     = 4'd0;
                    state_d     = S_REQ;
                end
            end

            S_FAULT: begin
                key_d       = '0;
                key_valid_d = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any load in progress immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: shadow key, beat/xor/timer bookkeeping, committed key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q    <= '0;
            beat_q      <= '0;
            xor_q       <= '0;
            timer_q     <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            retry_q     <= 4'd0;
        end else begin
            shadow_q    <= shadow_d;
            beat_q      <= beat_d;
            xor_q       <= xor_d;
            timer_q     <= timer_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            retry_q     <= retry_d;
        end
    end

    assign kd_req_o    = (state_q == S_REQ);
    assign kd_ready_o  = w_ready;
    assign busy_o      = (state_q == S_REQ) || w_ready;
    assign fault_o     = (state_q == S_FAULT);
    assign key_out_o   = key_q;
    assign key_valid_o = key_valid_q;
    assign retry_cnt_o = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_rll_key_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rll_key_loader
//  Description : Directed, table-driven bench for rll_key_loader with
//                hand-written sequences for timing, timeout and reset cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rll_key_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        kd_req;
    logic        kd_valid;
    logic [3:0]  kd_data;
    logic        kd_ready;
    logic [15:0] key_out;
    logic        key_valid;
    logic        busy;
    logic        fault;
    logic [3:0]  retry_cnt;

    int n_checks;
    int n_pass;

    rll_key_loader #(
        .KEY_W     (16),
        .CHUNK_W   (4),
        .MAX_RETRY (3),
        .TIMEOUT   (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .kd_req_o    (kd_req),
        .kd_valid_i  (kd_valid),
        .kd_data_i   (kd_data),
        .kd_ready_o  (kd_ready),
        .key_out_o   (key_out),
        .key_valid_o (key_valid),
        .busy_o      (busy),
        .fault_o     (fault),
        .retry_cnt_o (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        do_start;   // pulse start first (else already in REQ)
        logic [15:0] key;
        logic [3:0]  csum;
        logic        exp_ok;
        logic        exp_fault;
        logic [15:0] prev_key;   // key_out expected while loading
        logic [15:0] exp_key;    // key_out expected at the end
        logic [3:0]  exp_retry;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one beat and hold it until the loader accepts it.
    task automatic send_beat(input logic [3:0] d);
        int g;
        g = 0;
        kd_valid = 1'b1;
        kd_data  = d;
        while (kd_ready !== 1'b1 && g < 100) begin
            tick();
            g++;
        end
        if (g >= 100) check("kd_ready_wait", 32'(kd_ready), 32'd1);
        tick();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        kd_valid = 1'b0;
        kd_data  = 4'h0;
        tick();
        tick();
        check("rst_key_out",   32'(key_out),   32'h0);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_fault",     32'(fault),     32'd0);
        check("rst_retry",     32'(retry_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic apply(input vec_t v);
        logic [15:0] k;
        k = v.key;
        if (v.do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            check("req_pulse",     32'(kd_req),    32'd1);
            check("req_key_valid", 32'(key_valid), 32'd0);
            check("req_key_hold",  32'(key_out),   32'(v.prev_key));
        end
        tick();
        for (int b = 0; b < 4; b++) begin
            send_beat(k[15-4*b -: 4]);
        end
        send_beat(v.csum);
        kd_valid = 1'b0;
        if (v.exp_ok) begin
            check("commit_valid", 32'(key_valid), 32'd1);
            check("commit_key",   32'(key_out),   32'(v.exp_key));
            check("commit_retry", 32'(retry_cnt), 32'(v.exp_retry));
            check("commit_busy",  32'(busy),      32'd0);
        end else begin
            check("fail_valid",    32'(key_valid), 32'd0);
            check("fail_key_hold", 32'(key_out),   32'(v.prev_key));
            tick();
            if (v.exp_fault) begin
                check("fault_flag",  32'(fault),     32'd1);
                check("fault_key",   32'(key_out),   32'(v.exp_key));
                check("fault_ready", 32'(kd_ready),  32'd0);
                check("fault_valid", 32'(key_valid), 32'd0);
                check("fault_retry", 32'(retry_cnt), 32'(v.exp_retry));
            end else begin
                check("retry_req",   32'(kd_req),    32'd1);
                check("retry_cnt",   32'(retry_cnt), 32'(v.exp_retry));
                check("retry_fault", 32'(fault),     32'd0);
            end
        end
    endtask

    // Safety net so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        n_checks = 0;
        n_pass   = 0;

        //             start key      cs    ok    flt   prev     exp      retry
        vecs[0] = '{1'b1, 16'hB5C3, 4'h2, 1'b0, 1'b0, 16'hB5C3, 16'hB5C3, 4'd1};
        vecs[1] = '{1'b0, 16'hB5C3, 4'h1, 1'b1, 1'b0, 16'hB5C3, 16'hB5C3, 4'd1};
        vecs[2] = '{1'b1, 16'h0F0F, 4'h0, 1'b1, 1'b0, 16'hB5C3, 16'h0F0F, 4'd0};
        vecs[3] = '{1'b1, 16'h1234, 4'h4, 1'b1, 1'b0, 16'h0F0F, 16'h1234, 4'd0};
        vecs[4] = '{1'b1, 16'h1234, 4'h5, 1'b0, 1'b0, 16'h1234, 16'h1234, 4'd1};
        vecs[5] = '{1'b0, 16'h1234, 4'h0, 1'b0, 1'b0, 16'h1234, 16'h1234, 4'd2};
        vecs[6] = '{1'b0, 16'h1234, 4'h4, 1'b1, 1'b0, 16'h1234, 16'h1234, 4'd2};
        vecs[7] = '{1'b1, 16'hB5C3, 4'h2, 1'b0, 1'b0, 16'h1234, 16'h1234, 4'd1};
        vecs[8] = '{1'b0, 16'hB5C3, 4'h3, 1'b0, 1'b0, 16'h1234, 16'h1234, 4'd2};
        vecs[9] = '{1'b0, 16'hB5C3, 4'h0, 1'b0, 1'b1, 16'h1234, 16'h0000, 4'd3};

        rst_n    = 1'b0;
        start    = 1'b0;
        kd_valid = 1'b0;
        kd_data  = 4'h0;
        #12;
        do_reset();

        // Cycle-exact first load of 0xB5C3.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("c1_kd_req",   32'(kd_req),   32'd1);
        check("c1_kd_ready", 32'(kd_ready), 32'd0);
        check("c1_busy",     32'(busy),     32'd1);
        tick();
        check("c2_kd_ready", 32'(kd_ready), 32'd1);
        check("c2_kd_req",   32'(kd_req),   32'd0);
        kd_valid = 1'b1;
        kd_data = 4'hB; tick();
        kd_data = 4'h5; tick();
        kd_data = 4'hC; tick();
        kd_data = 4'h3; tick();
        check("c6_no_valid", 32'(key_valid), 32'd0);
        kd_data = 4'h1; tick();
        kd_valid = 1'b0;
        check("c7_key_valid", 32'(key_valid), 32'd1);
        check("c7_key_out",   32'(key_out),   32'hB5C3);
        check("c7_retry",     32'(retry_cnt), 32'd0);

        for (int i = 0; i < 10; i++) begin
            apply(vecs[i]);
        end

        // start is ignored once faulted.
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        check("fault_start_req",  32'(kd_req),  32'd0);
        check("fault_start_busy", 32'(busy),    32'd0);
        check("fault_sticky",     32'(fault),   32'd1);
        check("fault_key_zero",   32'(key_out), 32'h0);

        do_reset();

        // Timeout: stream goes quiet after the second beat.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        kd_valid = 1'b1;
        kd_data = 4'h1; tick();
        kd_data = 4'h2; tick();
        kd_valid = 1'b0;
        repeat (63) tick();
        check("to_still_ready", 32'(kd_ready), 32'd1);
        tick();
        check("to_fail_ready", 32'(kd_ready), 32'd0);
        check("to_fail_busy",  32'(busy),     32'd0);
        tick();
        check("to_req",   32'(kd_req),    32'd1);
        check("to_retry", 32'(retry_cnt), 32'd1);
        v = '{1'b0, 16'h1234, 4'h4, 1'b1, 1'b0, 16'h0000, 16'h1234, 4'd1};
        apply(v);

        // Asynchronous reset in the middle of a load.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        send_beat(4'h0);
        send_beat(4'hF);
        send_beat(4'h0);
        kd_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_key_out",   32'(key_out),   32'h0);
        check("ar_key_valid", 32'(key_valid), 32'd0);
        check("ar_busy",      32'(busy),      32'd0);
        check("ar_kd_ready",  32'(kd_ready),  32'd0);
        check("ar_kd_req",    32'(kd_req),    32'd0);
        check("ar_fault",     32'(fault),     32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_idle_busy", 32'(busy), 32'd0);
        v = '{1'b1, 16'h0F0F, 4'h0, 1'b1, 1'b0, 16'h0000, 16'h0F0F, 4'd0};
        apply(v);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
